// File: rtl/ysyx_22040632_icache_refill.sv
// Instruction-cache miss refill engine: picks a victim way, fetches the 64-byte
// line with one 8-beat AXI4 INCR burst, then installs the tag unless the fill was bad.
module ysyx_22040632_icache_refill (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        age_1st,
    input  logic        age_2nd,
    input  logic        fence_sig,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    output logic        data_wen,
    output logic        data_way,
    output logic [4:0]  data_index,
    output logic [2:0]  data_offset,
    output logic [63:0] data_wdata,
    output logic        tag_wen,
    output logic        w_way,
    output logic [20:0] addr_tag,
    output logic [4:0]  addr_index,
    output logic        resp_valid,
    output logic        resp_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_TAGW = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [25:0] line_q, line_d;
    logic        victim_q, victim_d;
    logic        err_q, err_d;
    logic        fence_q, fence_d;
    logic [2:0]  cnt_q, cnt_d;

    // The second age bit carries no extra information for a 2-way victim choice.
    logic unused_inputs;
    assign unused_inputs = ^{age_2nd, req_addr[5:0]};

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        victim_d = victim_q;
        err_d    = err_q;
        fence_d  = fence_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    line_d   = req_addr[31:6];
                    victim_d = age_1st;
                    err_d    = 1'b0;
                    fence_d  = 1'b0;
                    cnt_d    = 3'd0;
                    state_d  = S_AR;
                end
            end
            S_AR: begin
                if (arready) state_d = S_AR + 3'd1;
            end
            S_R: begin
                if (rvalid) begin
                    cnt_d = cnt_q + 3'd1;
                    // Any bad response or a burst length other than 8 poisons the line.
                    if ((rresp != 2'b00) || (rlast != (cnt_q == 3'd7))) err_d = 1'b1;
                    if (rlast) state_d = S_TAGW;
                end
            end
            S_TAGW:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if ((state_q != S_IDLE) && fence_sig) fence_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            line_q   <= '0;
            victim_q <= 1'b0;
            err_q    <= 1'b0;
            fence_q  <= 1'b0;
            cnt_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            victim_q <= victim_d;
            err_q    <= err_d;
            fence_q  <= fence_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign arvalid     = (state_q == S_AR);
    assign araddr      = {line_q, 6'b0};
    assign arlen       = 8'd7;
    assign arsize      = 3'd3;
    assign arburst     = 2'b01;
    assign rready      = (state_q == S_R);

    assign data_wen    = (state_q == S_R) && rvalid && !rst;
    assign data_way    = victim_q;
    assign data_index  = line_q[4:0];
    assign data_offset = cnt_q;
    assign data_wdata  = data_wen ? rdata : 64'd0;

    // A fence landing in the tag-write cycle itself also blocks the install.
    assign tag_wen     = !((state_q == S_TAGW) && !err_q && !fence_q && !fence_sig && !rst);
    assign w_way       = victim_q;
    assign addr_tag    = line_q[25:5];
    assign addr_index  = line_q[4:0];

    assign resp_valid  = (state_q == S_DONE) && !rst;
    assign resp_err    = resp_valid && (err_q || fence_q);

endmodule

// File: tb/tb_ysyx_22040632_icache_refill.sv
// Directed bench for the icache refill engine with a data-write scoreboard.
module tb_ysyx_22040632_icache_refill;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, age_1st, age_2nd, fence_sig;
    logic [31:0] req_addr, araddr;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [7:0]  arlen;
    logic [2:0]  arsize, data_offset;
    logic [1:0]  arburst, rresp;
    logic [63:0] rdata, data_wdata;
    logic        data_wen, data_way, tag_wen, w_way, resp_valid, resp_err;
    logic [4:0]  data_index, addr_index;
    logic [20:0] addr_tag;

    always #5 clk = ~clk;

    ysyx_22040632_icache_refill dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .age_1st(age_1st), .age_2nd(age_2nd), .fence_sig(fence_sig),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .rvalid(rvalid), .rready(rready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .data_wen(data_wen),
        .data_way(data_way), .data_index(data_index), .data_offset(data_offset),
        .data_wdata(data_wdata), .tag_wen(tag_wen), .w_way(w_way),
        .addr_tag(addr_tag), .addr_index(addr_index), .resp_valid(resp_valid),
        .resp_err(resp_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [72:0] sb[$];
    logic [72:0] mon_e;
    int          tag_cnt = 0, resp_cnt = 0, tag_cyc = 0, resp_cyc = 0;
    logic [26:0] tag_val = '0;
    logic        resp_err_s = 1'b0;
    logic [44:0] ar_val = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (data_wen === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_data_wen", data_wen, 0);
            else begin
                mon_e = sb.pop_front();
                chk("data_write", {data_way, data_index, data_offset, data_wdata}, mon_e);
            end
        end
        if (tag_wen === 1'b0) begin
            tag_cnt++;
            tag_cyc = cyc;
            tag_val = {w_way, addr_tag, addr_index};
        end
        if (resp_valid === 1'b1) begin
            resp_cnt++;
            resp_cyc = cyc;
            resp_err_s = resp_err;
        end
        if (arvalid === 1'b1) ar_val = {araddr, arlen, arsize, arburst};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [31:0] addr, input logic age1, input int ar_dly,
                             output int t0);
        req_valid = 1'b1; req_addr = addr; age_1st = age1; age_2nd = ~age1;
        t0 = cyc;
        step();
        req_valid = 1'b0; req_addr = 32'hDEAD_BEEF; age_1st = ~age1; age_2nd = age1;
        repeat (ar_dly) step();
        chk("arvalid", arvalid, 1);
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("ar_payload", ar_val, {addr[31:6], 6'b0, 8'd7, 3'd3, 2'b01});
    endtask

    task automatic beat(input logic [31:0] addr, input logic age1, input int b,
                        input logic [31:0] hi, input int err_beat, input int last_beat,
                        input int fence_beat);
        rvalid = 1'b1;
        rdata = {hi, 32'(b)};
        rresp = (b == err_beat) ? 2'b10 : 2'b00;
        rlast = (b == last_beat);
        fence_sig = (b == fence_beat);
        sb.push_back({age1, addr[10:6], 3'(b), rdata});
        step();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; fence_sig = 1'b0;
        rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    endtask

    task automatic refill(input string nm, input logic [31:0] addr, input logic age1,
                          input logic [31:0] hi, input int ar_dly, input int gap_after,
                          input int gap_len, input int err_beat, input int last_beat,
                          input int fence_beat, input logic exp_err, input int exp_resp_rel);
        int t0, tc0, rc0;
        tc0 = tag_cnt;
        rc0 = resp_cnt;
        chk({nm, "_req_ready_idle"}, req_ready, 1);
        start_req(addr, age1, ar_dly, t0);
        for (int b = 0; b <= last_beat; b++) begin
            beat(addr, age1, b, hi, err_beat, last_beat, fence_beat);
            if (b == gap_after) repeat (gap_len) step();
        end
        for (int i = 0; i < 20 && resp_cnt == rc0; i++) step();
        chk({nm, "_resp_count"}, resp_cnt - rc0, 1);
        chk({nm, "_resp_err"}, resp_err_s, exp_err);
        chk({nm, "_tag_writes"}, tag_cnt - tc0, exp_err ? 0 : 1);
        if (!exp_err) begin
            chk({nm, "_tag_entry"}, tag_val, {age1, addr[31:11], addr[10:6]});
            chk({nm, "_tag_cycle"}, tag_cyc - t0, exp_resp_rel - 1);
        end
        if (exp_resp_rel >= 0) chk({nm, "_resp_cycle"}, resp_cyc - t0, exp_resp_rel);
        chk({nm, "_beats_left"}, sb.size(), 0);
        chk({nm, "_req_ready_after"}, req_ready, 1);
    endtask

    initial begin
        int t0, rc0, tc0;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; age_1st = 1'b0; age_2nd = 1'b0;
        fence_sig = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_ctrl", {req_ready, arvalid, rready, data_wen, resp_valid, resp_err, tag_wen, w_way},
            8'b1000_0010);
        chk("reset_addr", {araddr, addr_tag, addr_index}, 0);
        chk("reset_data", {data_way, data_index, data_offset, data_wdata}, 0);

        refill("clean", 32'h8000_0A40, 1'b0, 32'h0, 0, -1, 0, -1, 7, -1, 1'b0, 11);
        chk("clean_tag_value", tag_val, {1'b0, 21'h100001, 5'd9});
        refill("victim_stall", 32'h1234_56C0, 1'b1, 32'h5A5A_0001, 3, 3, 2, -1, 7, -1, 1'b0, 16);
        refill("rresp_err", 32'h0000_1F80, 1'b0, 32'h0E44_0002, 0, -1, 0, 4, 7, -1, 1'b1, 11);
        refill("short_burst", 32'hFFFF_F7C0, 1'b1, 32'h5403_0003, 1, -1, 0, -1, 5, -1, 1'b1, -1);
        refill("fence_r", 32'h4000_0840, 1'b0, 32'hFE0C_0004, 0, -1, 0, -1, 7, 2, 1'b1, 11);

        fence_sig = 1'b1;
        step();
        fence_sig = 1'b0;
        refill("after_fence", 32'h4000_0840, 1'b1, 32'hA11C_0005, 0, -1, 0, -1, 7, -1, 1'b0, 11);

        rc0 = resp_cnt;
        tc0 = tag_cnt;
        start_req(32'h2468_ACC0, 1'b0, 0, t0);
        for (int b = 0; b < 4; b++) beat(32'h2468_ACC0, 1'b0, b, 32'h7E57_0006, -1, 7, -1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_ctrl", {req_ready, tag_wen, arvalid, rready, resp_valid}, 5'b11000);
        repeat (4) step();
        chk("rst_mid_no_resp", resp_cnt - rc0, 0);
        chk("rst_mid_no_tag", tag_cnt - tc0, 0);
        chk("rst_mid_beats", sb.size(), 0);

        refill("post_reset", 32'h0000_0000, 1'b0, 32'h0, 0, -1, 0, -1, 7, -1, 1'b0, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
